// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL,
    S_DROP
  } state_t;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam int unsigned TIMEOUT_DEF  = 16;
  localparam int unsigned TIMER_W_DEF  = $clog2(TIMEOUT_DEF);

  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/if_timeout_cnt.sv
// Response-wait counter: cleared on grant, counts while waiting, flags the last allowed cycle.
module if_timeout_cnt
  import if_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned W       = timer_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: one imem transaction per instruction, valid/ready to decode, pc_load on accept.
// Optional IF_MISALIGN_CHK_EN: misaligned pc yields a NOP with if_err instead of a memory request.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     TIMEOUT  = TIMEOUT_DEF,
  parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            fetch_en,
  input  logic            flush,
  output logic            pc_load,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic            if_err
);

  state_t          state, state_next;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] addr_src;
  logic            load_req;
  logic            cap_data;
  logic            cap_timeout;
  logic            cap_misalign;
  logic            cnt_clear;
  logic            cnt_en;
  logic            expired;
  logic            misalign;

  if_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

`ifdef IF_MISALIGN_CHK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // pc only settles the cycle after pc_load, so REQ addresses straight from pc
  // (stable throughout REQ) and req_pc tracks it for the response capture.
  assign addr_src = (state == S_REQ) ? pc : req_pc;

`ifdef IF_MISALIGN_CHK_EN
  assign imem_addr = addr_src;
`else
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  assign imem_addr = addr_src & ALIGN_MASK;
`endif

  assign if_valid = (state == S_FULL);

  always_comb begin
    state_next   = state;
    pc_load      = 1'b0;
    imem_req     = 1'b0;
    load_req     = 1'b0;
    cap_data     = 1'b0;
    cap_timeout  = 1'b0;
    cap_misalign = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state)
      S_IDLE: begin
        if (fetch_en && !flush) begin
          state_next = S_REQ;
          load_req   = 1'b1;
        end
      end
      S_REQ: begin
        imem_req  = !misalign;
        load_req  = 1'b1;
        cnt_clear = 1'b1;
        if (flush) begin
          state_next = (imem_req && imem_gnt) ? S_DROP : S_IDLE;
        end else if (misalign) begin
          state_next   = S_FULL;
          cap_misalign = 1'b1;
        end else if (imem_gnt) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_en = 1'b1;
        if (flush) begin
          state_next = S_DROP;
        end else if (imem_rvalid) begin
          state_next = S_FULL;
          cap_data   = 1'b1;
        end else if (expired) begin
          state_next  = S_FULL;
          cap_timeout = 1'b1;
        end
      end
      S_FULL: begin
        if (flush) begin
          state_next = S_IDLE;
        end else if (if_ready) begin
          pc_load    = 1'b1;
          state_next = fetch_en ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        cnt_en = 1'b1;
        if (!flush && (imem_rvalid || expired)) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      req_pc  <= '0;
      if_inst <= NOP_INST;
      if_pc   <= '0;
      if_err  <= 1'b0;
    end else begin
      state <= state_next;
      if (load_req) begin
        req_pc <= pc;
      end
      if (cap_data) begin
        if_inst <= imem_rdata;
        if_pc   <= req_pc;
        if_err  <= 1'b0;
      end else if (cap_timeout) begin
        if_inst <= NOP_INST;
        if_pc   <= req_pc;
        if_err  <= 1'b1;
      end else if (cap_misalign) begin
        if_inst <= NOP_INST;
        if_pc   <= pc;
        if_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a simple memory responder and pc model.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, fetch_en, flush, if_ready;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] pc, imem_rdata;
  logic        pc_load, imem_req, if_valid, if_err;
  logic [31:0] imem_addr, if_inst, if_pc;

  always #5 clk = ~clk;

  if_fetch_stage #(
    .XLEN     (32),
    .TIMEOUT  (16),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .fetch_en    (fetch_en),
    .flush       (flush),
    .pc_load     (pc_load),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_err      (if_err)
  );

  int checks = 0;
  int errors = 0;

  bit          mem_gnt_en, mem_rv_en, mem_fixed_en;
  logic [31:0] mem_fixed_data;
  bit          pend_rv;
  logic [31:0] pend_addr;

  logic        s_pc_load, s_req, s_gnt, s_valid, s_err;
  logic [31:0] s_addr, s_inst, s_pc;

  // One clock: memory responds at negedge, outputs sampled 1ns later, pc advances just after posedge.
  task automatic cycle(input bit force_rv, input logic [31:0] force_data);
    @(negedge clk);
    imem_gnt = mem_gnt_en && imem_req;
    if (force_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = force_data;
    end else if (mem_rv_en && pend_rv) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_fixed_en ? mem_fixed_data : (32'hA000_0000 | pend_addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    if (imem_rvalid) pend_rv = 1'b0;
    if (imem_gnt) begin
      pend_rv   = 1'b1;
      pend_addr = imem_addr;
    end
    #1;
    s_pc_load = pc_load;
    s_req     = imem_req;
    s_gnt     = imem_gnt;
    s_addr    = imem_addr;
    s_valid   = if_valid;
    s_inst    = if_inst;
    s_pc      = if_pc;
    s_err     = if_err;
    @(posedge clk);
    #1;
    if (s_pc_load) pc = pc + 32'd4;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    fetch_en     = 1'b0;
    flush        = 1'b0;
    if_ready     = 1'b0;
    mem_gnt_en   = 1'b1;
    mem_rv_en    = 1'b1;
    mem_fixed_en = 1'b0;
    pend_rv      = 1'b0;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_en = 1'b1; if_ready = 1'b1; pc = 32'h44;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h exp=0", s_valid); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0h exp=0", s_err); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0h exp=0", s_req); end
    checks++; if (s_pc_load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got=%0h exp=0", s_pc_load); end
    checks++; if (s_inst !== 32'h13) begin errors++; $display("FAIL reset_inst got=%08h exp=00000013", s_inst); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc got=%08h exp=0", s_pc); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%08h exp=0", s_addr); end
    rst = 1'b0; fetch_en = 1'b0; if_ready = 1'b0;
  endtask

  task automatic test_stream();
    int n = 0;
    int last = -1;
    logic [31:0] exp_pc;
    do_reset();
    pc = 32'h0; fetch_en = 1'b1; if_ready = 1'b1;
    for (int idx = 0; idx < 40 && n < 3; idx++) begin
      cycle(1'b0, '0);
      if (s_pc_load === 1'b1) begin
        exp_pc = 32'(n * 4);
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL stream_load_valid got=%0h exp=1", s_valid); end
        checks++; if (s_pc !== exp_pc) begin errors++; $display("FAIL stream_pc got=%08h exp=%08h", s_pc, exp_pc); end
        checks++; if (s_inst !== (32'hA000_0000 | exp_pc)) begin errors++; $display("FAIL stream_inst got=%08h exp=%08h", s_inst, 32'hA000_0000 | exp_pc); end
        checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL stream_err got=%0h exp=0", s_err); end
        if (n == 0) begin
          checks++; if (idx != 3) begin errors++; $display("FAIL stream_first_latency got=%0d exp=3", idx); end
        end else begin
          checks++; if (idx - last != 3) begin errors++; $display("FAIL stream_spacing got=%0d exp=3", idx - last); end
        end
        last = idx;
        n++;
      end
    end
    checks++; if (n != 3) begin errors++; $display("FAIL stream_count got=%0d exp=3", n); end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    do_reset();
    pc = 32'h100; fetch_en = 1'b1; if_ready = 1'b0;
    mem_fixed_en = 1'b1; mem_fixed_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, '0);
      if (s_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_reach_full got=%0d exp=1", seen); end
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, '0);
      checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%0h exp=1", s_valid); end
      checks++; if (s_inst !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bp_hold_inst got=%08h exp=deadbeef", s_inst); end
      checks++; if (s_pc_load !== 1'b0) begin errors++; $display("FAIL bp_no_load got=%0h exp=0", s_pc_load); end
    end
    if_ready = 1'b1;
    cycle(1'b0, '0);
    checks++; if (s_pc_load !== 1'b1) begin errors++; $display("FAIL bp_load_pulse got=%0h exp=1", s_pc_load); end
    checks++; if (s_pc !== 32'h100) begin errors++; $display("FAIL bp_if_pc got=%08h exp=00000100", s_pc); end
    cycle(1'b0, '0);
    checks++; if (s_pc_load !== 1'b0) begin errors++; $display("FAIL bp_single_pulse got=%0h exp=0", s_pc_load); end
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid got=%0h exp=0", s_valid); end
    if_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int gnt_idx = -1;
    int val_idx = -1;
    do_reset();
    pc = 32'h40; fetch_en = 1'b1; if_ready = 1'b0; mem_rv_en = 1'b0;
    for (int i = 0; i < 40 && val_idx < 0; i++) begin
      cycle(1'b0, '0);
      if (s_gnt === 1'b1 && gnt_idx < 0) gnt_idx = i;
      if (s_valid === 1'b1) val_idx = i;
    end
    checks++; if (gnt_idx != 1) begin errors++; $display("FAIL to_gnt_idx got=%0d exp=1", gnt_idx); end
    checks++; if (val_idx - gnt_idx - 1 != 16) begin errors++; $display("FAIL to_wait_cycles got=%0d exp=16", val_idx - gnt_idx - 1); end
    checks++; if (s_inst !== 32'h13) begin errors++; $display("FAIL to_inst got=%08h exp=00000013", s_inst); end
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL to_err got=%0h exp=1", s_err); end
    checks++; if (s_pc !== 32'h40) begin errors++; $display("FAIL to_if_pc got=%08h exp=00000040", s_pc); end
    fetch_en = 1'b0; if_ready = 1'b1;
    cycle(1'b0, '0);
    checks++; if (s_pc_load !== 1'b1) begin errors++; $display("FAIL to_accept got=%0h exp=1", s_pc_load); end
    if_ready = 1'b0;
  endtask

  task automatic test_timeout_race();
    do_reset();
    pc = 32'h50; fetch_en = 1'b1; if_ready = 1'b0; mem_rv_en = 1'b0;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    checks++; if (s_gnt !== 1'b1 || s_addr !== 32'h50) begin errors++; $display("FAIL race_req got=%0h/%08h exp=1/00000050", s_gnt, s_addr); end
    fetch_en = 1'b0;
    for (int i = 0; i < 15; i++) cycle(1'b0, '0);
    cycle(1'b1, 32'h0BAD_F00D);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL race_early_full got=%0h exp=0", s_valid); end
    cycle(1'b0, '0);
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL race_valid got=%0h exp=1", s_valid); end
    checks++; if (s_inst !== 32'h0BAD_F00D) begin errors++; $display("FAIL race_inst got=%08h exp=0badf00d", s_inst); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL race_err got=%0h exp=0", s_err); end
    checks++; if (s_pc !== 32'h50) begin errors++; $display("FAIL race_if_pc got=%08h exp=00000050", s_pc); end
  endtask

  task automatic test_flush_wait();
    int val_idx = -1;
    bit addr_ok = 1'b0;
    do_reset();
    pc = 32'h200; fetch_en = 1'b1; if_ready = 1'b1; mem_rv_en = 1'b0;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    flush = 1'b1;
    cycle(1'b0, '0);
    flush = 1'b0; pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      cycle(i == 2, 32'h1234_5678);
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL flush_drop_req got=%0h exp=0", s_req); end
      checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL flush_drop_valid got=%0h exp=0", s_valid); end
    end
    mem_rv_en = 1'b1;
    for (int i = 0; i < 10 && val_idx < 0; i++) begin
      cycle(1'b0, '0);
      if (s_gnt === 1'b1 && s_addr === 32'h300) addr_ok = 1'b1;
      if (s_valid === 1'b1) val_idx = i;
    end
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL flush_new_addr got=%0d exp=1", addr_ok); end
    checks++; if (val_idx != 3) begin errors++; $display("FAIL flush_refetch_latency got=%0d exp=3", val_idx); end
    checks++; if (s_inst !== 32'hA000_0300) begin errors++; $display("FAIL flush_inst got=%08h exp=a0000300", s_inst); end
    checks++; if (s_pc !== 32'h300) begin errors++; $display("FAIL flush_if_pc got=%08h exp=00000300", s_pc); end
    fetch_en = 1'b0;
  endtask

  task automatic test_flush_full();
    bit seen = 1'b0;
    do_reset();
    pc = 32'h20; fetch_en = 1'b1; if_ready = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, '0);
      if (s_valid === 1'b1) seen = 1'b1;
    end
    flush = 1'b1; if_ready = 1'b1; fetch_en = 1'b0;
    cycle(1'b0, '0);
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL ffull_valid got=%0h exp=1", s_valid); end
    checks++; if (s_pc_load !== 1'b0) begin errors++; $display("FAIL ffull_no_load got=%0h exp=0", s_pc_load); end
    flush = 1'b0;
    cycle(1'b0, '0);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL ffull_dropped got=%0h exp=0", s_valid); end
    checks++; if (s_pc_load !== 1'b0) begin errors++; $display("FAIL ffull_after_load got=%0h exp=0", s_pc_load); end
    if_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    pc = 32'h80; fetch_en = 1'b1; if_ready = 1'b1; mem_rv_en = 1'b0;
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    rst = 1'b1;
    cycle(1'b0, '0);
    rst = 1'b0; fetch_en = 1'b0;
    cycle(1'b1, 32'hCAFE_F00D);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0h exp=0", s_valid); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL rmid_err got=%0h exp=0", s_err); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL rmid_req got=%0h exp=0", s_req); end
    checks++; if (s_inst !== 32'h13) begin errors++; $display("FAIL rmid_inst got=%08h exp=00000013", s_inst); end
    checks++; if (s_pc !== 32'h0) begin errors++; $display("FAIL rmid_if_pc got=%08h exp=0", s_pc); end
    checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got=%08h exp=0", s_addr); end
    cycle(1'b0, '0);
    checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rmid_ignored_rvalid got=%0h exp=0", s_valid); end
    checks++; if (s_pc_load !== 1'b0) begin errors++; $display("FAIL rmid_pc_load got=%0h exp=0", s_pc_load); end
    if_ready = 1'b0;
  endtask

  task automatic test_misalign();
    bit seen = 1'b0;
    bit req_seen = 1'b0;
    do_reset();
    pc = 32'h6; fetch_en = 1'b1; if_ready = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, '0);
      if (s_req === 1'b1) req_seen = 1'b1;
      if (s_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (req_seen !== 1'b0) begin errors++; $display("FAIL mis_req got=%0d exp=0", req_seen); end
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got=%0h exp=1", s_valid); end
    checks++; if (s_err !== 1'b1) begin errors++; $display("FAIL mis_err got=%0h exp=1", s_err); end
    checks++; if (s_inst !== 32'h13) begin errors++; $display("FAIL mis_inst got=%08h exp=00000013", s_inst); end
    checks++; if (s_pc !== 32'h6) begin errors++; $display("FAIL mis_if_pc got=%08h exp=00000006", s_pc); end
`else
    cycle(1'b0, '0);
    cycle(1'b0, '0);
    if (s_req === 1'b1) req_seen = 1'b1;
    checks++; if (req_seen !== 1'b1) begin errors++; $display("FAIL align_req got=%0d exp=1", req_seen); end
    checks++; if (s_addr !== 32'h4) begin errors++; $display("FAIL align_addr got=%08h exp=00000004", s_addr); end
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1'b0, '0);
      if (s_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (s_inst !== 32'hA000_0004) begin errors++; $display("FAIL align_inst got=%08h exp=a0000004", s_inst); end
    checks++; if (s_err !== 1'b0) begin errors++; $display("FAIL align_err got=%0h exp=0", s_err); end
    checks++; if (s_pc !== 32'h6) begin errors++; $display("FAIL align_if_pc got=%08h exp=00000006", s_pc); end
`endif
    fetch_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; flush = 1'b0; if_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; pc = '0;
    mem_gnt_en = 1'b1; mem_rv_en = 1'b1; mem_fixed_en = 1'b0; mem_fixed_data = '0;
    pend_rv = 1'b0; pend_addr = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_timeout();
    test_timeout_race();
    test_flush_wait();
    test_flush_full();
    test_reset_mid();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage directly downstream of the PC controller. Captures the current pc and runs one request/grant/response transaction on the instruction-memory port. Presents the fetched instruction and its pc to decode through a valid/ready handshake. Emits a one-cycle pc_load back to the PC controller when decode accepts the instruction, so the pc advances exactly once per delivered instruction.

Parameters:
XLEN, 32, data/address width
TIMEOUT, 16, max cycles waiting for imem_rvalid after grant before a bus error is declared (>=2)
NOP_INST, 32'h00000013, instruction substituted on error

Ports:
clk  in  1  clock, all logic posedge
rst  in  1  synchronous active-high reset
pc  in  XLEN  current pc from PC controller, stable until pc_load
fetch_en  in  1  core run enable
flush  in  1  redirect/kill; discards in-flight fetch and held instruction
pc_load  out  1  to PC controller; advance pc at this edge
imem_req  out  1  memory request
imem_addr  out  XLEN  request address
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response data valid
imem_rdata  in  XLEN  response data
if_valid  out  1  instruction available to decode
if_ready  in  1  decode accepts
if_inst  out  XLEN  fetched instruction
if_pc  out  XLEN  pc of if_inst
if_err  out  1  bus error/timeout on this instruction

Behaviour:
- Reset: state IDLE; if_valid, if_err, imem_req, pc_load = 0; if_inst = NOP_INST; if_pc, imem_addr, timer = 0. Reset overrides all inputs, including mid-transaction.
- States: IDLE, REQ, WAIT, FULL, DROP.
- IDLE: if fetch_en & !flush, go to REQ and register req_pc <= pc.
- REQ: imem_req = 1 and imem_addr = req_pc, held until imem_gnt. On gnt, go to WAIT and clear timer. req/addr are stable while ungranted.
- WAIT: timer increments each cycle.
  - On imem_rvalid: if_inst <= imem_rdata, if_pc <= req_pc, if_err <= 0, go to FULL.
  - When timer reaches TIMEOUT-1 without rvalid: if_inst <= NOP_INST, if_err <= 1, go to FULL.
  - rvalid in the same cycle as the timeout: the data wins and no error is flagged.
- FULL: if_valid = 1; outputs are held stable until accepted.
  - On if_ready & !flush: pc_load = 1 combinationally in that cycle. Next state is REQ (req_pc <= pc at the following cycle, which is after the pc update) if fetch_en, else IDLE.
  - Best throughput with 1-cycle memory: one instruction every 3 cycles.
- flush has priority over every other event and deasserts if_valid the next cycle. It never asserts pc_load.
  - IDLE, REQ without gnt, or FULL: go to IDLE.
  - WAIT, or REQ with gnt in the same cycle: go to DROP.
- DROP: imem_req = 0. Wait for imem_rvalid or timeout, discard the result, go to IDLE. A second flush in DROP stays in DROP.
- imem_rvalid outside WAIT/DROP is ignored.
- fetch_en low only stops new requests. An outstanding transaction still completes.
- pc_load is never asserted outside FULL and at most once per fetched instruction.

Optional Feature:
IF_MISALIGN_CHK_EN
- Defined: on REQ entry, if pc[1:0] != 0, no memory request is issued. Go directly to FULL with if_inst = NOP_INST, if_pc = pc, if_err = 1.
- Undefined: imem_addr = {req_pc[XLEN-1:2], 2'b00} and no misalignment error exists.

Decomposition:
- Package if_pkg: state encoding enum, NOP_INST constant, default TIMEOUT, timer width $clog2(TIMEOUT).
- Sub-module if_timeout_cnt: clear/enable/expired counter, shared by WAIT and DROP.
- FSM and datapath registers remain in if_fetch_stage.

Test Plan:
- gnt and rvalid each 1 cycle after request, if_ready = 1, pc = 0x0, 0x4, 0x8 -> if_inst/if_pc pairs delivered in order, pc_load pulses once per instruction, 3-cycle spacing.
- if_ready held 0 for 5 cycles in FULL with rdata = 0xDEADBEEF -> if_valid stays 1, if_inst stable, pc_load = 0 until ready rises, then exactly one pulse.
- No rvalid after gnt, TIMEOUT = 16 -> FULL after 16 WAIT cycles, if_inst = 0x00000013, if_err = 1, if_pc = req_pc.
- flush in WAIT, rvalid 3 cycles later with 0x12345678 -> data discarded, if_valid never rises for it, returns to IDLE, next fetch uses the new pc.
- rst asserted in WAIT, then rvalid arrives -> all outputs at reset values, rvalid ignored, no pc_load.
- (IF_MISALIGN_CHK_EN) pc = 0x6 -> imem_req never asserts, if_err = 1, if_pc = 0x6.
